// File: rtl/ls_buffer_pkg.sv
// Shared types and constants for the load/store buffer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ls_buffer_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int ROB_W_DEF = 4;

    localparam logic [ADDR_W-1:0] IO_ADDR_DEF = 32'h30000;

    // Loads occupy the codes up to and including OPNUM_LHU, stores sit above.
    typedef enum logic [5:0] {
        OPNUM_NOP = 6'd0,
        OPNUM_LB  = 6'd1,
        OPNUM_LH  = 6'd2,
        OPNUM_LW  = 6'd3,
        OPNUM_LBU = 6'd4,
        OPNUM_LHU = 6'd5,
        OPNUM_SB  = 6'd6,
        OPNUM_SH  = 6'd7,
        OPNUM_SW  = 6'd8
    } opnum_e;

    localparam int OPNUM_W = $bits(opnum_e);

    function automatic logic is_store(input logic [OPNUM_W-1:0] op);
        return op > OPNUM_W'(OPNUM_LHU);
    endfunction

endpackage

// File: rtl/lsb_cdb_match.sv
// Compares one operand tag against every result broadcast channel; lowest channel wins.
// Latency: combinational.
// Backpressure: none; pure compare.
// Ports: tag (operand tag, all-ones = no match), cdb_valid/cdb_rob_id/cdb_data
//        (flattened broadcast channels), hit / data (match flag and its value).
module lsb_cdb_match
    import ls_buffer_pkg::*;
#(
    parameter int NUM_CDB = 2,
    parameter int ROB_W   = 4
) (
    input  logic [ROB_W-1:0]          tag,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0]  cdb_rob_id,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
    output logic                      hit,
    output logic [DATA_W-1:0]         data
);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        // Walk from the top channel down so the lowest matching index is the last writer.
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && (cdb_rob_id[k*ROB_W +: ROB_W] == tag) && (tag != '1)) begin
                hit  = 1'b1;
                data = cdb_data[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/ls_buffer.sv
// In-order load/store buffer between dispatch and the memory executor; snoops result broadcasts.
// Latency: insert -> earliest ex_en two edges later; commit of a head store -> ex_en two edges later.
// Backpressure: head holds while ex_full; full_o raised at LSB_DEPTH-FULL_MARGIN; rdy low freezes all state.
// Ports: clk/rst (sync, active high), rdy; in_* insert from dispatch; cdb_* broadcasts;
//        commit_en/commit_rob_id, rob_head_id, rollback from the ROB; ex_full/ex_* to the executor;
//        io_rob_id (head rob id when head targets IO_ADDR), full_o, stall_cnt.
// Optional: define LSB_STALL_CNT_EN to build the saturating head-stall counter; otherwise stall_cnt is 0.
module ls_buffer
    import ls_buffer_pkg::*;
#(
    parameter int                LSB_DEPTH   = 16,
    parameter int                NUM_CDB     = 2,
    parameter int                ROB_W       = ROB_W_DEF,
    parameter int                FULL_MARGIN = 5,
    parameter logic [ADDR_W-1:0] IO_ADDR     = IO_ADDR_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      in_en,
    input  logic [OPNUM_W-1:0]        in_opnum,
    input  logic [DATA_W-1:0]         in_v1,
    input  logic [DATA_W-1:0]         in_v2,
    input  logic [ROB_W-1:0]          in_q1,
    input  logic [ROB_W-1:0]          in_q2,
    input  logic [DATA_W-1:0]         in_imm,
    input  logic [ROB_W-1:0]          in_rob_id,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0]  cdb_rob_id,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
    input  logic                      commit_en,
    input  logic [ROB_W-1:0]          commit_rob_id,
    input  logic [ROB_W-1:0]          rob_head_id,
    input  logic                      rollback,
    output logic [ROB_W-1:0]          io_rob_id,
    input  logic                      ex_full,
    output logic                      ex_en,
    output logic [OPNUM_W-1:0]        ex_opnum,
    output logic [ADDR_W-1:0]         ex_addr,
    output logic [DATA_W-1:0]         ex_sdata,
    output logic [ROB_W-1:0]          ex_rob_id,
    output logic                      full_o,
    output logic [31:0]               stall_cnt
);

    localparam int                PTR_W       = $clog2(LSB_DEPTH);
    localparam logic [ROB_W-1:0]  INVALID_ROB = '1;
    localparam logic [PTR_W-1:0]  PTR_ONE     = PTR_W'(1);
    localparam logic [PTR_W:0]    CNT_ONE     = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]    CNT_MAX     = (PTR_W+1)'(LSB_DEPTH);
    localparam logic [PTR_W:0]    CNT_FULL    = (PTR_W+1)'(LSB_DEPTH - FULL_MARGIN);

    // Entry storage
    logic                busy      [LSB_DEPTH];
    logic                committed [LSB_DEPTH];
    logic [OPNUM_W-1:0]  e_op      [LSB_DEPTH];
    logic [DATA_W-1:0]   e_v1      [LSB_DEPTH];
    logic [DATA_W-1:0]   e_v2      [LSB_DEPTH];
    logic [DATA_W-1:0]   e_imm     [LSB_DEPTH];
    logic [ROB_W-1:0]    e_q1      [LSB_DEPTH];
    logic [ROB_W-1:0]    e_q2      [LSB_DEPTH];
    logic [ROB_W-1:0]    e_rob     [LSB_DEPTH];

    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [PTR_W:0]      count;
    logic [PTR_W-1:0]    last_ptr;
    logic                last_vld;

    // Broadcast snoop for every stored operand plus the insert bypass
    logic                q1_hit [LSB_DEPTH];
    logic                q2_hit [LSB_DEPTH];
    logic [DATA_W-1:0]   q1_dat [LSB_DEPTH];
    logic [DATA_W-1:0]   q2_dat [LSB_DEPTH];
    logic                ins_hit1, ins_hit2;
    logic [DATA_W-1:0]   ins_dat1, ins_dat2;

    for (genvar i = 0; i < LSB_DEPTH; i++) begin : g_snoop
        lsb_cdb_match #(.NUM_CDB(NUM_CDB), .ROB_W(ROB_W)) u_m1 (
            .tag        (e_q1[i]),
            .cdb_valid  (cdb_valid),
            .cdb_rob_id (cdb_rob_id),
            .cdb_data   (cdb_data),
            .hit        (q1_hit[i]),
            .data       (q1_dat[i])
        );
        lsb_cdb_match #(.NUM_CDB(NUM_CDB), .ROB_W(ROB_W)) u_m2 (
            .tag        (e_q2[i]),
            .cdb_valid  (cdb_valid),
            .cdb_rob_id (cdb_rob_id),
            .cdb_data   (cdb_data),
            .hit        (q2_hit[i]),
            .data       (q2_dat[i])
        );
    end

    lsb_cdb_match #(.NUM_CDB(NUM_CDB), .ROB_W(ROB_W)) u_ins1 (
        .tag        (in_q1),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_data   (cdb_data),
        .hit        (ins_hit1),
        .data       (ins_dat1)
    );
    lsb_cdb_match #(.NUM_CDB(NUM_CDB), .ROB_W(ROB_W)) u_ins2 (
        .tag        (in_q2),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_data   (cdb_data),
        .hit        (ins_hit2),
        .data       (ins_dat2)
    );

    // Head issue decision, from registered state only
    logic [ADDR_W-1:0] head_addr;
    logic              head_ops_rdy;
    logic              head_ok;
    logic              issue;
    logic              ins_ok;

    assign head_addr    = e_v1[head] + e_imm[head];
    assign head_ops_rdy = (e_q1[head] == INVALID_ROB) && (e_q2[head] == INVALID_ROB);
    // Stores wait for commit; MMIO loads wait until they are the oldest op in the ROB.
    assign head_ok      = is_store(e_op[head]) ? committed[head]
                        : ((head_addr != IO_ADDR) || (rob_head_id == e_rob[head]));
    assign issue        = busy[head] && head_ops_rdy && !ex_full && head_ok && !rollback;
    // A full buffer can still accept when the head frees its slot the same cycle.
    assign ins_ok       = in_en && ((count != CNT_MAX) || issue);

    assign io_rob_id = (busy[head] && (e_q1[head] == INVALID_ROB) && (head_addr == IO_ADDR))
                     ? e_rob[head] : INVALID_ROB;
    assign full_o    = (count >= CNT_FULL);

    always_ff @(posedge clk) begin
        if (rst || (rdy && rollback && !last_vld)) begin
            for (int i = 0; i < LSB_DEPTH; i++) begin
                busy[i]      <= 1'b0;
                committed[i] <= 1'b0;
                e_op[i]      <= '0;
                e_v1[i]      <= '0;
                e_v2[i]      <= '0;
                e_imm[i]     <= '0;
                e_q1[i]      <= INVALID_ROB;
                e_q2[i]      <= INVALID_ROB;
                e_rob[i]     <= '0;
            end
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            last_ptr  <= '0;
            last_vld  <= 1'b0;
            ex_en     <= 1'b0;
            ex_opnum  <= '0;
            ex_addr   <= '0;
            ex_sdata  <= '0;
            ex_rob_id <= '0;
        end else if (rdy) begin
            if (rollback) begin
                // Committed stores from head up to last_ptr survive; everything else is dropped.
                for (int i = 0; i < LSB_DEPTH; i++) begin
                    if (!committed[i] || !is_store(e_op[i])) begin
                        busy[i]      <= 1'b0;
                        committed[i] <= 1'b0;
                    end
                end
                tail  <= last_ptr + PTR_ONE;
                count <= {1'b0, last_ptr - head} + CNT_ONE;
                ex_en <= 1'b0;
            end else begin
                // Clear last_store before commit so a same-cycle commit of another store wins.
                if (issue && last_vld && (last_ptr == head)) begin
                    last_vld <= 1'b0;
                end

                for (int i = 0; i < LSB_DEPTH; i++) begin
                    if (busy[i]) begin
                        if (q1_hit[i]) begin
                            e_v1[i] <= q1_dat[i];
                            e_q1[i] <= INVALID_ROB;
                        end
                        if (q2_hit[i]) begin
                            e_v2[i] <= q2_dat[i];
                            e_q2[i] <= INVALID_ROB;
                        end
                        if (commit_en && !committed[i] && (e_rob[i] == commit_rob_id)) begin
                            committed[i] <= 1'b1;
                            if (is_store(e_op[i])) begin
                                last_ptr <= PTR_W'(i);
                                last_vld <= 1'b1;
                            end
                        end
                    end
                end

                ex_en <= issue;
                if (issue) begin
                    ex_opnum     <= e_op[head];
                    ex_addr      <= head_addr;
                    ex_sdata     <= e_v2[head];
                    ex_rob_id    <= e_rob[head];
                    busy[head]      <= 1'b0;
                    committed[head] <= 1'b0;
                    head         <= head + PTR_ONE;
                end

                // Insert last: when full with a same-cycle issue, tail == head and the new entry must win.
                if (ins_ok) begin
                    busy[tail]      <= 1'b1;
                    committed[tail] <= 1'b0;
                    e_op[tail]      <= in_opnum;
                    e_v1[tail]      <= ins_hit1 ? ins_dat1 : in_v1;
                    e_q1[tail]      <= ins_hit1 ? INVALID_ROB : in_q1;
                    e_v2[tail]      <= ins_hit2 ? ins_dat2 : in_v2;
                    e_q2[tail]      <= ins_hit2 ? INVALID_ROB : in_q2;
                    e_imm[tail]     <= in_imm;
                    e_rob[tail]     <= in_rob_id;
                    tail            <= tail + PTR_ONE;
                end

                count <= count + (PTR_W+1)'(ins_ok) - (PTR_W+1)'(issue);
            end
        end
    end

`ifdef LSB_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (rdy && busy[head] && !issue && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

    // Dispatch must never push into a full buffer unless the head leaves the same cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(rdy && !rollback && in_en && (count == CNT_MAX) && !issue));

endmodule

// File: tb/tb_ls_buffer.sv
// Directed self-checking bench for ls_buffer (default parameters).
// Latency: n/a.
// Backpressure: drives ex_full / rdy directly.
module tb_ls_buffer;
    import ls_buffer_pkg::*;

    localparam logic [5:0] OP_LW = 6'd3;
    localparam logic [5:0] OP_SW = 6'd8;
    localparam logic [3:0] INV   = 4'hF;

    logic         clk = 1'b0;
    logic         rst, rdy, in_en;
    logic [5:0]   in_opnum;
    logic [31:0]  in_v1, in_v2, in_imm;
    logic [3:0]   in_q1, in_q2, in_rob_id;
    logic [1:0]   cdb_valid;
    logic [7:0]   cdb_rob_id;
    logic [63:0]  cdb_data;
    logic         commit_en;
    logic [3:0]   commit_rob_id, rob_head_id;
    logic         rollback;
    logic [3:0]   io_rob_id;
    logic         ex_full, ex_en;
    logic [5:0]   ex_opnum;
    logic [31:0]  ex_addr, ex_sdata;
    logic [3:0]   ex_rob_id;
    logic         full_o;
    logic [31:0]  stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ls_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .in_en         (in_en),
        .in_opnum      (in_opnum),
        .in_v1         (in_v1),
        .in_v2         (in_v2),
        .in_q1         (in_q1),
        .in_q2         (in_q2),
        .in_imm        (in_imm),
        .in_rob_id     (in_rob_id),
        .cdb_valid     (cdb_valid),
        .cdb_rob_id    (cdb_rob_id),
        .cdb_data      (cdb_data),
        .commit_en     (commit_en),
        .commit_rob_id (commit_rob_id),
        .rob_head_id   (rob_head_id),
        .rollback      (rollback),
        .io_rob_id     (io_rob_id),
        .ex_full       (ex_full),
        .ex_en         (ex_en),
        .ex_opnum      (ex_opnum),
        .ex_addr       (ex_addr),
        .ex_sdata      (ex_sdata),
        .ex_rob_id     (ex_rob_id),
        .full_o        (full_o),
        .stall_cnt     (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        in_en = 1'b0; in_opnum = '0; in_v1 = '0; in_v2 = '0; in_imm = '0;
        in_q1 = INV; in_q2 = INV; in_rob_id = '0;
        cdb_valid = '0; cdb_rob_id = '0; cdb_data = '0;
        commit_en = 1'b0; commit_rob_id = '0; rollback = 1'b0;
    endtask

    task automatic ins(input logic [5:0] op, input logic [31:0] v1, input logic [3:0] q1,
                       input logic [31:0] v2, input logic [31:0] imm, input logic [3:0] rob);
        in_en = 1'b1; in_opnum = op; in_v1 = v1; in_q1 = q1; in_v2 = v2; in_q2 = INV;
        in_imm = imm; in_rob_id = rob;
        step();
        in_en = 1'b0; in_q1 = INV;
    endtask

    initial begin
        logic seen;
        int   guard;

        clr_in();
        rst = 1'b1; rdy = 1'b1; ex_full = 1'b0; rob_head_id = 4'd0;
        step(); step();
        rst = 1'b0;

        // Reset state
        check("rst_ex_en", 32'(ex_en), 0);
        check("rst_count", 32'(dut.count), 0);
        check("rst_full", 32'(full_o), 0);
        check("rst_io_rob", 32'(io_rob_id), 32'hF);
        check("rst_ex_addr", ex_addr, 0);
        check("rst_stall", stall_cnt, 0);

        // 1: plain ready load
        ins(OP_LW, 32'h100, INV, 0, 32'h4, 4'd1);
        check("t1_cnt1", 32'(dut.count), 1);
        check("t1_no_en", 32'(ex_en), 0);
        step();
        check("t1_en", 32'(ex_en), 1);
        check("t1_addr", ex_addr, 32'h104);
        check("t1_op", 32'(ex_opnum), 32'(OP_LW));
        check("t1_rob", 32'(ex_rob_id), 1);
        check("t1_cnt0", 32'(dut.count), 0);
        step();
        check("t1_pulse", 32'(ex_en), 0);

        // Reset while an issue is pending: no strobe
        ins(OP_LW, 32'h10, INV, 0, 0, 4'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rsti_en", 32'(ex_en), 0);
        check("rsti_cnt", 32'(dut.count), 0);
        step();
        check("rsti_en2", 32'(ex_en), 0);

        // 2: store waits for commit
        ins(OP_SW, 32'h200, INV, 32'hDEADBEEF, 32'h8, 4'd1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen = seen | ex_en;
        end
        check("t2_hold", 32'(seen), 0);
        check("t2_cnt", 32'(dut.count), 1);
        commit_en = 1'b1; commit_rob_id = 4'd1;
        step();
        commit_en = 1'b0;
        check("t2_not_same", 32'(ex_en), 0);
        step();
        check("t2_en", 32'(ex_en), 1);
        check("t2_sdata", ex_sdata, 32'hDEADBEEF);
        check("t2_addr", ex_addr, 32'h208);
        check("t2_op", 32'(ex_opnum), 32'(OP_SW));
        step();

        // 3: insert-time CDB bypass on channel 1
        cdb_valid = 2'b10; cdb_rob_id = 8'h30; cdb_data = {32'h55, 32'h0};
        ins(OP_LW, 32'h0, 4'd3, 0, 32'h10, 4'd5);
        cdb_valid = '0;
        step();
        check("t3_en", 32'(ex_en), 1);
        check("t3_addr", ex_addr, 32'h65);

        // 3b: duplicate tag on both channels, channel 0 wins
        cdb_valid = 2'b11; cdb_rob_id = 8'h66; cdb_data = {32'h2000, 32'h1000};
        ins(OP_LW, 32'h0, 4'd6, 0, 32'h8, 4'd7);
        cdb_valid = '0;
        step();
        check("t3b_addr", ex_addr, 32'h1008);

        // 3c: stored entry snoops a later broadcast
        ins(OP_LW, 32'h0, 4'd9, 0, 32'h20, 4'd8);
        step();
        check("t3c_wait", 32'(ex_en), 0);
        cdb_valid = 2'b01; cdb_rob_id = 8'h09; cdb_data = {32'h0, 32'h300};
        step();
        cdb_valid = '0;
        check("t3c_snoop_edge", 32'(ex_en), 0);
        step();
        check("t3c_en", 32'(ex_en), 1);
        check("t3c_addr", ex_addr, 32'h320);
        step();

        // 4: rollback keeps the committed store only
        ex_full = 1'b1;
        ins(OP_SW, 32'h400, INV, 32'hCAFE, 32'h0, 4'd2);
        commit_en = 1'b1; commit_rob_id = 4'd2;
        ins(OP_LW, 32'h0, 4'd10, 0, 0, 4'd3);
        commit_en = 1'b0;
        ins(OP_LW, 32'h40, INV, 0, 0, 4'd4);
        check("t4_cnt3", 32'(dut.count), 3);
        rollback = 1'b1;
        step();
        rollback = 1'b0;
        check("t4_cnt1", 32'(dut.count), 1);
        check("t4_no_en", 32'(ex_en), 0);
        ex_full = 1'b0;
        step();
        check("t4_en", 32'(ex_en), 1);
        check("t4_rob", 32'(ex_rob_id), 2);
        check("t4_sdata", ex_sdata, 32'hCAFE);
        step();
        check("t4_empty", 32'(dut.count), 0);
        check("t4_no_more", 32'(ex_en), 0);

        // 4b: rollback without a committed store empties the buffer
        ins(OP_LW, 32'h0, 4'd11, 0, 0, 4'd5);
        rollback = 1'b1;
        step();
        rollback = 1'b0;
        check("t4b_cnt", 32'(dut.count), 0);

        // 5: MMIO load waits for ROB head
        rob_head_id = 4'd1;
        ins(OP_LW, 32'h2FFF0, INV, 0, 32'h10, 4'd6);
        check("t5_io_rob", 32'(io_rob_id), 6);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen = seen | ex_en;
        end
        check("t5_blocked", 32'(seen), 0);
        rob_head_id = 4'd6;
        step();
        check("t5_en", 32'(ex_en), 1);
        check("t5_addr", ex_addr, 32'h30000);
        check("t5_io_clear", 32'(io_rob_id), 32'hF);
        rob_head_id = 4'd0;
        step();

        // 6: fill to the full threshold, then freeze with rdy low
        ex_full = 1'b1;
        for (int i = 0; i < 11; i++) begin
            ins(OP_LW, 32'(i * 4), INV, 0, 0, 4'(i));
            if (i == 9) check("t6_not_full", 32'(full_o), 0);
        end
        check("t6_full", 32'(full_o), 1);
        check("t6_cnt", 32'(dut.count), 11);
        rdy = 1'b0; ex_full = 1'b0;
        in_en = 1'b1; in_opnum = OP_LW; in_rob_id = 4'd12;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            seen = seen | ex_en;
        end
        in_en = 1'b0;
        check("t6_frozen_en", 32'(seen), 0);
        check("t6_frozen_cnt", 32'(dut.count), 11);
        rdy = 1'b1;
        step();
        check("t6_en", 32'(ex_en), 1);
        check("t6_rob", 32'(ex_rob_id), 0);
        check("t6_cnt10", 32'(dut.count), 10);
        check("t6_unfull", 32'(full_o), 0);
        guard = 0;
        while (dut.count != 0 && guard < 40) begin
            step();
            guard++;
        end
        check("t6_drained", 32'(guard < 40), 1);
        check("t6_last_rob", 32'(ex_rob_id), 10);

`ifndef LSB_STALL_CNT_EN
        check("stall_tied", stall_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
